// File: rtl/enemy_sched_pkg.sv
// enemy_sched_pkg: shared types and constants for the enemy scheduler.
//   sched_state_e : scheduler FSM states (idle, spawning, steady play, all dead)
//   DIR_*         : direction codes handed to the enemy motion modules
//   LFSR_TAPS     : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
package enemy_sched_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSpawn = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } sched_state_e;

    localparam logic [2:0] DIR_DOWN  = 3'd1;
    localparam logic [2:0] DIR_UP    = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_RIGHT = 3'd4;

    // Bit 15 is tap 16, bit 13 tap 14, bit 12 tap 13, bit 10 tap 11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/enemy_lfsr.sv
// enemy_lfsr: free-running 16-bit Fibonacci LFSR shared by all enemies.
//   clk    : system clock
//   reset  : asynchronous active-high reset, loads SEED
//   rand_o : two low state bits, used to form a direction code
module enemy_lfsr
    import enemy_sched_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] rand_o
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_o = lfsr_q[1:0];

endmodule

// File: rtl/enemy_scheduler.sv
// enemy_scheduler: spawns enemies on frame boundaries, tracks alive enemies and kills,
// and round-robin arbitrates the shared LFSR among enemies requesting a new direction.
//   clk, reset   : system clock, asynchronous active-high reset
//   startOfFrame : one-cycle pulse per frame
//   game_on      : high while a round is running
//   kill         : per-enemy destroy pulse
//   enemy_req    : per-enemy request for a new direction code
//   enemy_en     : per-enemy enable (alive and released)
//   grant        : one-hot, one-cycle grant; random_num valid for that enemy
//   random_num   : direction code 1..4 during a grant, else 0
//   all_dead     : every enemy killed this round
//   kill_count   : saturating kill counter for the round
// Optional feature macro: ENEMY_RESPAWN_EN (killed enemies re-spawn after
// SPAWN_DELAY_FRAMES frames; all_dead then never asserts).
module enemy_scheduler
    import enemy_sched_pkg::*;
#(
    parameter int unsigned NUM_ENEMIES        = 4,
    parameter int unsigned SPAWN_DELAY_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   game_on,
    input  logic [NUM_ENEMIES-1:0] kill,
    input  logic [NUM_ENEMIES-1:0] enemy_req,
    output logic [NUM_ENEMIES-1:0] enemy_en,
    output logic [NUM_ENEMIES-1:0] grant,
    output logic [2:0]             random_num,
    output logic                   all_dead,
    output logic [7:0]             kill_count
);

    localparam int unsigned IdxW = $clog2(NUM_ENEMIES);
    localparam int unsigned CntW = (SPAWN_DELAY_FRAMES > 1) ? $clog2(SPAWN_DELAY_FRAMES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SPAWN_DELAY_FRAMES - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_ENEMIES - 1);
    localparam logic [IdxW:0]   NumEn   = (IdxW + 1)'(NUM_ENEMIES);

    sched_state_e           state_q, state_d;
    logic [NUM_ENEMIES-1:0] enemy_en_q, enemy_en_d;
    logic [NUM_ENEMIES-1:0] grant_q, grant_d;
    logic [2:0]             random_num_q, random_num_d;
    logic                   all_dead_q, all_dead_d;
    logic [7:0]             kill_count_q, kill_count_d;
    logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]        frame_cnt_q, frame_cnt_d;
    logic [IdxW-1:0]        spawn_idx_q, spawn_idx_d;

    logic [1:0]             lfsr_bits;
    logic                   active;
    logic [NUM_ENEMIES-1:0] valid_kill;
    logic [NUM_ENEMIES-1:0] release_vec;
    logic [NUM_ENEMIES-1:0] respawn_vec;
    logic [NUM_ENEMIES-1:0] elig;
    logic [8:0]             kill_total;
    logic [IdxW:0]          cand;
    logic                   found;

    enemy_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .rand_o (lfsr_bits)
    );

    assign active     = (state_q == StSpawn) || (state_q == StRun);
    assign valid_kill = kill & enemy_en_q;

    always_comb begin
        kill_total = {1'b0, kill_count_q};
        for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
            kill_total = kill_total + {8'd0, valid_kill[i]};
        end
    end

`ifdef ENEMY_RESPAWN_EN
    logic [NUM_ENEMIES-1:0] resp_pend_q, resp_pend_d;
    logic [CntW-1:0]        resp_cnt_q [NUM_ENEMIES];
    logic [CntW-1:0]        resp_cnt_d [NUM_ENEMIES];

    // Per-enemy frame counter that restarts when the enemy is killed.
    always_comb begin
        respawn_vec = '0;
        resp_pend_d = resp_pend_q;
        resp_cnt_d  = resp_cnt_q;
        if (!game_on || !active) begin
            resp_pend_d = '0;
        end else begin
            for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
                if (valid_kill[i]) begin
                    resp_pend_d[i] = 1'b1;
                    resp_cnt_d[i]  = '0;
                end else if (resp_pend_q[i] && startOfFrame) begin
                    if (resp_cnt_q[i] == CntLast) begin
                        respawn_vec[i] = 1'b1;
                        resp_pend_d[i] = 1'b0;
                        resp_cnt_d[i]  = '0;
                    end else begin
                        resp_cnt_d[i] = resp_cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_pend_q <= '0;
            for (int unsigned i = 0; i < NUM_ENEMIES; i++) resp_cnt_q[i] <= '0;
        end else begin
            resp_pend_q <= resp_pend_d;
            resp_cnt_q  <= resp_cnt_d;
        end
    end
`else
    assign respawn_vec = '0;
`endif

    always_comb begin
        state_d      = state_q;
        enemy_en_d   = enemy_en_q;
        grant_d      = '0;
        random_num_d = 3'd0;
        all_dead_d   = all_dead_q;
        kill_count_d = kill_count_q;
        rr_ptr_d     = rr_ptr_q;
        frame_cnt_d  = frame_cnt_q;
        spawn_idx_d  = spawn_idx_q;
        release_vec  = '0;
        elig         = '0;
        cand         = '0;
        found        = 1'b0;

        unique case (state_q)
            StIdle: begin
                enemy_en_d   = '0;
                all_dead_d   = 1'b0;
                kill_count_d = 8'd0;
                rr_ptr_d     = '0;
                if (game_on) begin
                    state_d     = StSpawn;
                    frame_cnt_d = '0;
                    spawn_idx_d = '0;
                end
            end
            StSpawn: begin
                if (startOfFrame) begin
                    // Spawn index 0 marks the first frame after entry: release at once.
                    if ((spawn_idx_q == '0) || (frame_cnt_q == CntLast)) begin
                        release_vec[spawn_idx_q] = 1'b1;
                        frame_cnt_d = '0;
                        spawn_idx_d = spawn_idx_q + 1'b1;
                        if (spawn_idx_q == IdxLast) state_d = StRun;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            StRun: begin
`ifndef ENEMY_RESPAWN_EN
                if (enemy_en_q == '0) begin
                    state_d    = StDone;
                    all_dead_d = 1'b1;
                end
`endif
            end
            StDone: begin
                all_dead_d = 1'b1;
            end
            default: ;
        endcase

        if (active) begin
            enemy_en_d   = (enemy_en_q | release_vec | respawn_vec) & ~valid_kill;
            kill_count_d = kill_total[8] ? 8'hFF : kill_total[7:0];
            // Current grantee is masked so a held request waits at least one idle cycle;
            // a same-cycle kill drops the victim from arbitration.
            elig = enemy_req & enemy_en_q & ~grant_q & ~kill;
            for (int unsigned off = 0; off < NUM_ENEMIES; off++) begin
                cand = {1'b0, rr_ptr_q} + (IdxW + 1)'(off);
                if (cand >= NumEn) cand = cand - NumEn;
                if (!found && elig[cand[IdxW-1:0]]) begin
                    found                      = 1'b1;
                    grant_d[cand[IdxW-1:0]]    = 1'b1;
                    rr_ptr_d = (cand[IdxW-1:0] == IdxLast) ? '0 : cand[IdxW-1:0] + 1'b1;
                end
            end
            if (found) random_num_d = DIR_DOWN + {1'b0, lfsr_bits};
        end

        if (!game_on) begin
            state_d      = StIdle;
            enemy_en_d   = '0;
            all_dead_d   = 1'b0;
            kill_count_d = 8'd0;
            grant_d      = '0;
            random_num_d = 3'd0;
            rr_ptr_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            enemy_en_q   <= '0;
            grant_q      <= '0;
            random_num_q <= 3'd0;
            all_dead_q   <= 1'b0;
            kill_count_q <= 8'd0;
            rr_ptr_q     <= '0;
            frame_cnt_q  <= '0;
            spawn_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            enemy_en_q   <= enemy_en_d;
            grant_q      <= grant_d;
            random_num_q <= random_num_d;
            all_dead_q   <= all_dead_d;
            kill_count_q <= kill_count_d;
            rr_ptr_q     <= rr_ptr_d;
            frame_cnt_q  <= frame_cnt_d;
            spawn_idx_q  <= spawn_idx_d;
        end
    end

    assign enemy_en   = enemy_en_q;
    assign grant      = grant_q;
    assign random_num = random_num_q;
    assign all_dead   = all_dead_q;
    assign kill_count = kill_count_q;

endmodule

// File: tb/tb_enemy_scheduler.sv
// tb_enemy_scheduler: directed self-checking bench for enemy_scheduler
// (4 enemies, 2-frame spawn delay, default seed).
module tb_enemy_scheduler;
    import enemy_sched_pkg::*;

    localparam int unsigned   N    = 4;
    localparam int unsigned   D    = 2;
    localparam logic [15:0]   SEED = 16'hACE1;

    logic         clk = 1'b0;
    logic         reset;
    logic         sof;
    logic         game_on;
    logic [N-1:0] kill;
    logic [N-1:0] enemy_req;
    logic [N-1:0] enemy_en;
    logic [N-1:0] grant;
    logic [2:0]   random_num;
    logic         all_dead;
    logic [7:0]   kill_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Independent LFSR model; m_prev is the state the DUT used at the last edge.
    logic [15:0] m_q, m_prev;

    enemy_scheduler #(
        .NUM_ENEMIES        (N),
        .SPAWN_DELAY_FRAMES (D),
        .LFSR_SEED          (SEED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (sof),
        .game_on      (game_on),
        .kill         (kill),
        .enemy_req    (enemy_req),
        .enemy_en     (enemy_en),
        .grant        (grant),
        .random_num   (random_num),
        .all_dead     (all_dead),
        .kill_count   (kill_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q    <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_q;
            m_q    <= lfsr_next(m_q);
        end
    end

    function automatic logic [2:0] exp_dir(input logic [15:0] v);
        return {1'b0, v[1:0]} + 3'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] exp_en [7];

    initial begin
        exp_en = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b1111};
        reset     = 1'b1;
        sof       = 1'b0;
        game_on   = 1'b0;
        kill      = '0;
        enemy_req = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en", 32'(enemy_en), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_rnd", 32'(random_num), 32'h0);
        check("rst_all_dead", 32'(all_dead), 32'h0);
        check("rst_kc", 32'(kill_count), 32'h0);
        check("rst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'(SEED));
        reset = 1'b0;
        tick();

        // Spawn sequence: releases on frame pulses 1, 3, 5, 7.
        game_on = 1'b1;
        tick();
        for (int p = 0; p < 7; p++) begin
            sof = 1'b1;
            tick();
            check($sformatf("spawn_en_p%0d", p + 1), 32'(enemy_en), 32'(exp_en[p]));
            sof = 1'b0;
            tick();
        end
        check("state_run", 32'(dut.state_q), 32'(StRun));

        // Round-robin grants with all requests held.
        enemy_req = 4'hF;
        for (int g = 0; g < 4; g++) begin
            tick();
            check($sformatf("rr_grant%0d", g), 32'(grant), 32'(4'b0001 << g));
            check($sformatf("rr_rnd%0d", g), 32'(random_num), 32'(exp_dir(m_prev)));
        end
        enemy_req = '0;
        tick();
        check("rr_idle_grant", 32'(grant), 32'h0);
        check("rr_idle_rnd", 32'(random_num), 32'h0);

        // Kill on a requester suppresses its grant; next eligible wins.
        enemy_req = 4'b1100;
        kill      = 4'b0100;
        tick();
        enemy_req = '0;
        kill      = '0;
        check("sup_grant", 32'(grant), 32'b1000);
        check("sup_rnd", 32'(random_num), 32'(exp_dir(m_prev)));
        check("sup_en", 32'(enemy_en), 32'b1011);
        check("sup_kc", 32'(kill_count), 32'd1);
        tick();
        check("sup_grant_off", 32'(grant), 32'h0);

        // Multi-bit kill counts popcount; a kill on a dead enemy is ignored.
        kill = 4'b0011;
        tick();
        kill = '0;
        check("kill2_en", 32'(enemy_en), 32'b1000);
        check("kill2_kc", 32'(kill_count), 32'd3);
        kill = 4'b0100;
        tick();
        kill = '0;
        check("kill_dead_en", 32'(enemy_en), 32'b1000);
        check("kill_dead_kc", 32'(kill_count), 32'd3);

        // Last kill, all_dead one cycle later, then game_on drop clears.
        kill = 4'b1000;
        tick();
        kill = '0;
        check("last_en", 32'(enemy_en), 32'h0);
        check("last_kc", 32'(kill_count), 32'd4);
        check("last_all_dead_early", 32'(all_dead), 32'h0);
        tick();
        check("all_dead", 32'(all_dead), 32'h1);
        check("state_done", 32'(dut.state_q), 32'(StDone));
        game_on = 1'b0;
        tick();
        check("off_all_dead", 32'(all_dead), 32'h0);
        check("off_kc", 32'(kill_count), 32'h0);
        check("off_en", 32'(enemy_en), 32'h0);

        // Reset mid-spawn with an active grant.
        game_on = 1'b1;
        tick();
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check("r6_en", 32'(enemy_en), 32'b0001);
        enemy_req = 4'b0001;
        tick();
        check("r6_grant", 32'(grant), 32'b0001);
        #2;
        reset = 1'b1;
        #1;
        check("r6_async_en", 32'(enemy_en), 32'h0);
        check("r6_async_grant", 32'(grant), 32'h0);
        check("r6_async_rnd", 32'(random_num), 32'h0);
        check("r6_async_kc", 32'(kill_count), 32'h0);
        check("r6_async_all_dead", 32'(all_dead), 32'h0);
        check("r6_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'(SEED));
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("r6_post_grant", 32'(grant), 32'h0);
        check("r6_post_en", 32'(enemy_en), 32'h0);
        tick();
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check("r6_respawn_en", 32'(enemy_en), 32'b0001);
        tick();
        check("r6_regrant", 32'(grant), 32'b0001);
        check("r6_regrant_rnd", 32'(random_num), 32'(exp_dir(m_prev)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
